// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, memory-stage FSM encoding and control-word bit positions
// shared by the control block and the memory stage of the 8-bit CPU.
package cpu_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        PROG_ACCEPT = 2'd1,
        PROG_DONE   = 2'd2,
        CLEAR       = 2'd3
    } mem_state_t;

    // Active-low memory controls inside the control word.
    localparam int SIG_MAR_ADDR_LOAD_N = 11;
    localparam int SIG_MAR_MEM_LOAD_N  = 10;
    localparam int SIG_RAM_EN_N        = 9;
    localparam int SIG_RAM_LOAD_N      = 8;

endpackage

// File: rtl/ram_16x8.sv
// ram_16x8: register-file RAM with one synchronous write port and one
// asynchronous (zero-latency) read port. Contents are never reset.
module ram_16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port: one location per clock when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/memory_block.sv
// memory_block: CPU memory stage (MAR, MDR, 16x8 RAM) with a byte-stream
// programming port used to load the program image before the CPU runs.
// Build macro MEMORY_BLOCK_CLEAR_EN: after reset release the RAM is
// zero-filled (CLEAR state, one location per cycle) before the CPU may use it.
module memory_block #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mar_addr_load_n,
    input  logic              mar_mem_load_n,
    input  logic              ram_en_n,
    input  logic              ram_load_n,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic              busy
);

    import cpu_pkg::*;

    mem_state_t        state;
    mem_state_t        state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [ADDR_W-1:0] prog_ptr;
    logic [ADDR_W-1:0] prog_ptr_nxt;
    logic              cpu_act;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

`ifdef MEMORY_BLOCK_CLEAR_EN
    // clr_pending marks the first cycle after reset release, before CLEAR starts;
    // the CPU and the programming port are locked out during it.
    logic              clr_pending;
    logic [ADDR_W-1:0] clr_ptr;

    assign cpu_act = (state == RUN) && !clr_pending;
`else
    assign cpu_act = (state == RUN);
`endif

    // Next-state logic and write-port arbitration between CPU, loader and clear.
    always_comb begin
        state_nxt    = state;
        prog_ptr_nxt = prog_ptr;
        we           = 1'b0;
        waddr        = mar;
        wdata        = mdr;
        case (state)
            RUN: begin
                we = cpu_act && !ram_load_n;
                if (cpu_act && prog_mode) begin
                    state_nxt    = PROG_ACCEPT;
                    prog_ptr_nxt = '0;
                end
`ifdef MEMORY_BLOCK_CLEAR_EN
                if (clr_pending) begin
                    state_nxt = CLEAR;
                end
`endif
            end
            PROG_ACCEPT: begin
                waddr = prog_ptr;
                wdata = prog_data;
                if (prog_valid) begin
                    we           = 1'b1;
                    prog_ptr_nxt = prog_ptr + ADDR_W'(1);
                    if (&prog_ptr) begin
                        state_nxt = PROG_DONE;
                    end
                end
                if (!prog_mode) begin
                    state_nxt    = RUN;
                    prog_ptr_nxt = '0;
                end
            end
            PROG_DONE: begin
                if (!prog_mode) begin
                    state_nxt    = RUN;
                    prog_ptr_nxt = '0;
                end
            end
`ifdef MEMORY_BLOCK_CLEAR_EN
            CLEAR: begin
                we    = 1'b1;
                waddr = clr_ptr;
                wdata = '0;
                if (&clr_ptr) begin
                    state_nxt = RUN;
                end
            end
`endif
            default: begin
                state_nxt    = RUN;
                prog_ptr_nxt = '0;
            end
        endcase
    end

    // FSM state and programming pointer; reset aborts any load in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            prog_ptr <= '0;
        end else begin
            state    <= state_nxt;
            prog_ptr <= prog_ptr_nxt;
        end
    end

    // MAR and MDR load from the bus only while the CPU owns the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar <= '0;
            mdr <= '0;
        end else if (cpu_act) begin
            if (!mar_addr_load_n) begin
                mar <= bus_in[ADDR_W-1:0];
            end
            if (!mar_mem_load_n) begin
                mdr <= bus_in;
            end
        end
    end

`ifdef MEMORY_BLOCK_CLEAR_EN
    // Clear sequencing: arm on reset, then walk every address once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_pending <= 1'b1;
            clr_ptr     <= '0;
        end else begin
            clr_pending <= 1'b0;
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + ADDR_W'(1);
            end
        end
    end
`endif

    ram_16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (mar),
        .rdata (rdata)
    );

    assign bus_oe     = cpu_act && !ram_en_n;
    assign bus_out    = bus_oe ? rdata : '0;
    assign prog_ready = (state == PROG_ACCEPT);
    assign prog_done  = (state == PROG_DONE);
    assign busy       = (state != RUN);

endmodule

// File: tb/tb_memory_block.sv
// tb_memory_block: table-driven and randomized self-checking bench for memory_block.
`timescale 1ns/1ps
module tb_memory_block;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       prog_mode, prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready, prog_done, busy;

    always #5 clk = ~clk;

    memory_block #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mar_addr_load_n (mar_addr_load_n),
        .mar_mem_load_n  (mar_mem_load_n),
        .ram_en_n        (ram_en_n),
        .ram_load_n      (ram_load_n),
        .bus_in          (bus_in),
        .bus_out         (bus_out),
        .bus_oe          (bus_oe),
        .prog_mode       (prog_mode),
        .prog_valid      (prog_valid),
        .prog_data       (prog_data),
        .prog_ready      (prog_ready),
        .prog_done       (prog_done),
        .busy            (busy)
    );

    typedef struct {
        logic [3:0] ctl;   // {mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n}
        logic [7:0] bus;
        logic       oe;
        logic [7:0] out;
    } vec_t;

    vec_t tbl[25];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain array memory with a "known" flag per location.
    logic [7:0] m_ram [16];
    bit         m_known [16];
    logic [3:0] m_mar;
    logic [7:0] m_mdr;

    function automatic vec_t v(input logic [3:0] c, input logic [7:0] b, input logic oe, input logic [7:0] o);
        vec_t r;
        r.ctl = c; r.bus = b; r.oe = oe; r.out = o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ctrl(input logic [3:0] c, input logic [7:0] b);
        {mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n} = c;
        bus_in = b;
    endtask

    task automatic idle();
        ctrl(4'b1111, 8'h00);
        prog_mode = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic rd_chk(input string nm, input logic [3:0] a, input logic [7:0] exp);
        ctrl(4'b0111, {4'h0, a}); step();
        ctrl(4'b1101, 8'h00); #1;
        chk({nm, "_oe"}, bus_oe, 1);
        chk(nm, bus_out, exp);
        step(); idle();
    endtask

    task automatic do_reset();
        idle(); rst_n = 1'b0; #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", prog_ready, 0);
        chk("rst_done", prog_done, 0);
        chk("rst_oe", bus_oe, 0);
        chk("rst_out", bus_out, 0);
        step(); rst_n = 1'b1;
    endtask

`ifdef MEMORY_BLOCK_CLEAR_EN
    task automatic wait_clear();
        int hi = 0, fall = 0, rdy = 0;
        for (int k = 1; k <= 40 && fall == 0; k++) begin
            step();
            if (prog_ready) rdy++;
            if (busy) hi++;
            else if (hi > 0) fall = k;
        end
        chk("clr_busy_cycles", hi, 16);
        chk("clr_fall_edge", fall, 17);
        chk("clr_prog_ignored", rdy, 0);
    endtask
`endif

    task automatic settle();
`ifdef MEMORY_BLOCK_CLEAR_EN
        wait_clear();
`endif
    endtask

    task automatic rand_run();
        logic [3:0] c = 4'($urandom);
        logic [7:0] b = 8'($urandom);
        ctrl(c, b); #1;
        chk("rnd_oe", bus_oe, !c[1]);
        if (c[1]) chk("rnd_out_idle", bus_out, 0);
        else if (m_known[m_mar]) chk("rnd_out", bus_out, m_ram[m_mar]);
        step();
        if (!c[0]) begin m_ram[m_mar] = m_mdr; m_known[m_mar] = 1; end
        if (!c[3]) m_mar = b[3:0];
        if (!c[2]) m_mdr = b;
        idle();
    endtask

    task automatic rand_prog();
        int n = $urandom_range(1, 40);
        int cnt = 0;
        logic vld;
        prog_mode = 1'b1; step();
        for (int k = 0; k < n; k++) begin
            ctrl(4'($urandom), 8'($urandom));
            vld = 1'($urandom);
            prog_valid = vld; prog_data = 8'($urandom); #1;
            chk("rp_ready", prog_ready, cnt < 16);
            chk("rp_done", prog_done, cnt == 16);
            chk("rp_busy", busy, 1);
            chk("rp_oe", bus_oe, 0);
            step();
            if (vld && cnt < 16) begin
                m_ram[cnt] = prog_data; m_known[cnt] = 1; cnt++;
            end
        end
        idle(); step(); #1;
        chk("rp_exit_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nrdy;
        // Basic access and ordering corner cases; MAR/MDR start from reset (0).
        tbl[0]  = v(4'b1110, 8'h00, 1'b0, 8'h00); // write MDR(0) to RAM[0]
        tbl[1]  = v(4'b1101, 8'h00, 1'b1, 8'h00);
        tbl[2]  = v(4'b0111, 8'h0A, 1'b0, 8'h00);
        tbl[3]  = v(4'b1011, 8'h5C, 1'b0, 8'h00);
        tbl[4]  = v(4'b1110, 8'h00, 1'b0, 8'h00);
        tbl[5]  = v(4'b1101, 8'h00, 1'b1, 8'h5C);
        tbl[6]  = v(4'b0111, 8'h07, 1'b0, 8'h00);
        tbl[7]  = v(4'b1011, 8'h77, 1'b0, 8'h00);
        tbl[8]  = v(4'b1110, 8'h00, 1'b0, 8'h00);
        tbl[9]  = v(4'b0111, 8'h03, 1'b0, 8'h00);
        tbl[10] = v(4'b1011, 8'h11, 1'b0, 8'h00);
        tbl[11] = v(4'b0110, 8'h07, 1'b0, 8'h00); // MAR load + write: old MAR
        tbl[12] = v(4'b1101, 8'h00, 1'b1, 8'h77); // RAM[7] untouched
        tbl[13] = v(4'b0111, 8'h03, 1'b0, 8'h00);
        tbl[14] = v(4'b1101, 8'h00, 1'b1, 8'h11);
        tbl[15] = v(4'b1011, 8'h22, 1'b0, 8'h00);
        tbl[16] = v(4'b1100, 8'h00, 1'b1, 8'h11); // read during write: pre-write value
        tbl[17] = v(4'b1101, 8'h00, 1'b1, 8'h22);
        tbl[18] = v(4'b0111, 8'h05, 1'b0, 8'h00);
        tbl[19] = v(4'b1010, 8'h66, 1'b0, 8'h00); // MDR load + write: old MDR
        tbl[20] = v(4'b1101, 8'h00, 1'b1, 8'h22);
        tbl[21] = v(4'b1110, 8'h00, 1'b0, 8'h00);
        tbl[22] = v(4'b1101, 8'h00, 1'b1, 8'h66);
        tbl[23] = v(4'b0101, 8'h0A, 1'b1, 8'h66); // read uses old MAR
        tbl[24] = v(4'b1101, 8'h00, 1'b1, 8'h5C);

        idle();
        do_reset();
        settle();

        foreach (tbl[i]) begin
            ctrl(tbl[i].ctl, tbl[i].bus); #1;
            chk($sformatf("vec%0d_oe", i), bus_oe, tbl[i].oe);
            chk($sformatf("vec%0d_out", i), bus_out, tbl[i].out);
            step();
        end
        idle();

        // Programming stream with a gap after every byte.
        prog_mode = 1'b1; step();
        nrdy = 0;
        for (int i = 0; i < 16; i++) begin
            prog_valid = 1'b1; prog_data = 8'hF0 + 8'(i); #1;
            if (!prog_ready) nrdy++;
            step();
            prog_valid = 1'b0; #1;
            if (i < 15 && !prog_ready) nrdy++;
            step();
        end
        chk("prog_ready_throughout", nrdy, 0);
        chk("prog_done_set", prog_done, 1);
        chk("prog_done_ready", prog_ready, 0);
        chk("prog_done_busy", busy, 1);
        prog_valid = 1'b1; prog_data = 8'h00; step();
        prog_valid = 1'b0; #1;
        chk("prog_done_hold", prog_done, 1);
        prog_mode = 1'b0; step(); #1;
        chk("prog_exit_busy", busy, 0);
        chk("prog_exit_done", prog_done, 0);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("prog_rd%0d", i), 4'(i), 8'hF0 + 8'(i));

        // Control ignored while loading, then reset aborts after 5 bytes.
        ctrl(4'b1011, 8'h99); step(); idle();
        prog_mode = 1'b1; step();
        for (int i = 0; i < 5; i++) begin
            ctrl(4'b0000, 8'h03);
            prog_valid = 1'b1; prog_data = 8'hA0 + 8'(i); #1;
            chk($sformatf("ign_oe%0d", i), bus_oe, 0);
            chk($sformatf("ign_out%0d", i), bus_out, 0);
            step();
        end
        #2 rst_n = 1'b0; #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", prog_ready, 0);
        idle(); step(); rst_n = 1'b1;
`ifdef MEMORY_BLOCK_CLEAR_EN
        wait_clear();
`else
        ctrl(4'b1101, 8'h00); #1;
        chk("abort_mar0", bus_out, 8'hA0);
        step(); idle();
        rd_chk("abort_no_cpu_wr", 4'hF, 8'hFF);
        for (int i = 0; i < 5; i++) rd_chk($sformatf("abort_rd%0d", i), 4'(i), 8'hA0 + 8'(i));
        rd_chk("abort_rd5", 4'h5, 8'hF5);
        prog_mode = 1'b1; step();
        prog_valid = 1'b1; prog_data = 8'hB0; step();
        idle(); step();
        rd_chk("ptr_reset_rd0", 4'h0, 8'hB0);
        rd_chk("ptr_reset_rd1", 4'h1, 8'hA1);
`endif

`ifdef MEMORY_BLOCK_CLEAR_EN
        // Preload a pattern, then reset with prog_mode held: RAM must read zero.
        prog_mode = 1'b1; step();
        for (int i = 0; i < 16; i++) begin
            prog_valid = 1'b1; prog_data = 8'h5A ^ 8'(i); step();
        end
        idle(); step();
        rd_chk("pre_clr_rd3", 4'h3, 8'h59);
        rst_n = 1'b0; step();
        prog_mode = 1'b1; rst_n = 1'b1;
        wait_clear();
        prog_mode = 1'b0;
        for (int i = 0; i < 16; i++) rd_chk($sformatf("clr_rd%0d", i), 4'(i), 8'h00);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        settle();
        m_mar = 4'h0; m_mdr = 8'h00;
        for (int i = 0; i < 16; i++) begin
            m_ram[i] = 8'h00;
`ifdef MEMORY_BLOCK_CLEAR_EN
            m_known[i] = 1;
`else
            m_known[i] = 0;
`endif
        end
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 24) == 0) rand_prog();
            else rand_run();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
